life_grid: RTL

- Parametrised Game-of-Life engine: WIDTH x HEIGHT cell array held in flops.
- Computes one full generation per clock while running.
- Programmable birth/survive rule masks; selectable toroidal or dead-border edges.
- Run control: step count, early stop on extinction or still-life, generation counter. Serves as the array-level successor to the single-cell rule evaluator.

---
 rtl/life_grid.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/life_grid.sv
// Game-of-Life array engine: a WIDTH x HEIGHT grid held in flops that
// advances one full generation per clock while running.
// Birth/survive rule masks and the edge mode are captured at start.
// A run stops early when the grid dies out or stops changing.
module life_grid #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned GEN_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       load_en_i,
  input  logic [$clog2(HEIGHT)-1:0]  load_row_i,
  input  logic [WIDTH-1:0]           load_data_i,
  input  logic                       start_i,
  input  logic [GEN_W-1:0]           run_steps_i,
  input  logic [8:0]                 rule_birth_i,
  input  logic [8:0]                 rule_survive_i,
  input  logic                       wrap_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [WIDTH*HEIGHT-1:0]    grid_o,
  output logic [GEN_W-1:0]           gen_count_o,
  output logic                       extinct_o,
  output logic                       stable_o
);

  localparam int unsigned Cells = WIDTH * HEIGHT;
  localparam int unsigned RowW  = $clog2(HEIGHT);
  localparam int          W     = int'(WIDTH);
  localparam int          H     = int'(HEIGHT);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [Cells-1:0]   grid_q, grid_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [GEN_W-1:0]   rem_q, rem_d;
  logic [8:0]         birth_q, birth_d;
  logic [8:0]         surv_q, surv_d;
  logic               wrap_q, wrap_d;
  logic               stable_q, stable_d;
  logic               done_q, done_d;
  logic               pend_q, pend_d;
  logic [Cells-1:0]   next_grid;

  // Value of cell (r, c) where r/c may lie one step outside the array.
  // Torus mode folds the index back in; otherwise outside cells are dead.
  function automatic logic cell_at(input logic [Cells-1:0] g, input int r, input int c,
                                   input logic w);
    int rr;
    int cc;
    rr = r;
    cc = c;
    if (w) begin
      if (rr < 0) rr = H - 1;
      else if (rr >= H) rr = 0;
      if (cc < 0) cc = W - 1;
      else if (cc >= W) cc = 0;
    end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
      return 1'b0;
    end
    return g[rr*W + cc];
  endfunction

  // Successor generation for every cell, using the registered rules.
  always_comb begin
    logic [3:0] n;
    next_grid = '0;
    n         = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
              n = n + {3'b000, cell_at(grid_q, r + dr, c + dc, wrap_q)};
            end
          end
        end
        next_grid[r*W + c] = grid_q[r*W + c] ? surv_q[n] : birth_q[n];
      end
    end
  end

  // Control: loading and start handling in idle, generation stepping in run.
  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    gen_d    = gen_q;
    rem_d    = rem_q;
    birth_d  = birth_q;
    surv_d   = surv_q;
    wrap_d   = wrap_q;
    stable_d = stable_q;
    done_d   = 1'b0;
    pend_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          // Start arrived together with a load; parameters were captured last
          // cycle and are now judged against the freshly loaded grid.
          if (rem_q == '0 || grid_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else begin
          if (load_en_i) begin
            // Row indices past the last row match no row and are dropped.
            for (int r = 0; r < H; r++) begin
              if (load_row_i == RowW'(r)) begin
                grid_d[r*W +: WIDTH] = load_data_i;
              end
            end
            stable_d = 1'b0;
          end
          if (start_i) begin
            rem_d    = run_steps_i;
            birth_d  = rule_birth_i;
            surv_d   = rule_survive_i;
            wrap_d   = wrap_i;
            gen_d    = '0;
            stable_d = 1'b0;
            if (load_en_i) begin
              pend_d = 1'b1;
            end else if (run_steps_i == '0 || grid_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = StRun;
            end
          end
        end
      end

      StRun: begin
        grid_d   = next_grid;
        gen_d    = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
        rem_d    = rem_q - GEN_W'(1);
        stable_d = (next_grid == grid_q);
        if (rem_q == GEN_W'(1) || next_grid == grid_q || next_grid == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      grid_q   <= '0;
      gen_q    <= '0;
      rem_q    <= '0;
      birth_q  <= '0;
      surv_q   <= '0;
      wrap_q   <= 1'b0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      gen_q    <= gen_d;
      rem_q    <= rem_d;
      birth_q  <= birth_d;
      surv_q   <= surv_d;
      wrap_q   <= wrap_d;
      stable_q <= stable_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
    end
  end

  // Output mapping.
  always_comb begin
    busy_o      = (state_q == StRun);
    done_o      = done_q;
    grid_o      = grid_q;
    gen_count_o = gen_q;
    extinct_o   = (grid_q == '0);
    stable_o    = stable_q;
  end

endmodule
